// File: rtl/up_sample_and_expand.sv
// Playback up-sampler: expands 8-bit offset-binary samples to 16-bit signed PCM and
// emits 2**UP_LOG2 beats per input, by linear interpolation or zero-order hold.
module up_sample_and_expand #(
  parameter int unsigned UP_LOG2 = 1,
  parameter bit          INTERP  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [7:0]  data_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [15:0] data_out
);

  localparam int unsigned L  = 1 << UP_LOG2;
  localparam int unsigned KW = 5;
  localparam int unsigned PW = 17 + UP_LOG2 + 1;

  typedef enum logic {S_WAIT, S_EMIT} state_t;

  state_t             state, state_d;
  logic signed [15:0] prev, prev_d;
  logic signed [15:0] cur, cur_d;
  logic signed [16:0] delta, delta_d;
  logic [KW-1:0]      k, k_d;
  logic [15:0]        data_d;
  logic               valid_d;

  logic signed [15:0] x;
  logic signed [15:0] base;
  logic signed [16:0] delta_new;
  logic               last;
  logic               load;

  // y_k = base + (d*k) >>> UP_LOG2; exact because d is a multiple of 256
  function automatic logic [15:0] interp(input logic signed [15:0] b,
                                         input logic signed [16:0] d,
                                         input logic [KW-1:0] kk);
    logic signed [PW-1:0] prod;
    prod = PW'(d) * $signed(PW'(kk));
    return 16'(b) + 16'(prod >>> UP_LOG2);
  endfunction

  assign x = {~data_in[7], data_in[6:0], 8'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      prev      <= '0;
      cur       <= '0;
      delta     <= '0;
      k         <= KW'(1);
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_d;
      prev      <= prev_d;
      cur       <= cur_d;
      delta     <= delta_d;
      k         <= k_d;
      data_out  <= data_d;
      valid_out <= valid_d;
    end
  end

  // Next-state and handshake logic; the last beat doubles as an accept slot
  always_comb begin
    state_d   = state;
    prev_d    = prev;
    cur_d     = cur;
    delta_d   = delta;
    k_d       = k;
    data_d    = data_out;
    valid_d   = valid_out;
    base      = prev;
    load      = 1'b0;
    last      = (k == KW'(L));
    ready_in  = 1'b0;

    case (state)
      S_WAIT: begin
        ready_in = 1'b1;
        load     = valid_in;
      end
      S_EMIT: begin
        ready_in = last && ready_out;
        if (ready_out) begin
          if (!last) begin
            k_d    = k + KW'(1);
            data_d = INTERP ? interp(prev, delta, k + KW'(1)) : cur;
          end else begin
            prev_d = cur;
            base   = cur;
            if (valid_in) begin
              load = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = S_WAIT;
            end
          end
        end
      end
      default: state_d = S_WAIT;
    endcase

    delta_new = {x[15], x} - {base[15], base};
    if (load) begin
      cur_d   = x;
      delta_d = delta_new;
      k_d     = KW'(1);
      data_d  = INTERP ? interp(base, delta_new, KW'(1)) : x;
      valid_d = 1'b1;
      state_d = S_EMIT;
    end
  end

endmodule

// File: tb/tb_up_sample_and_expand.sv
// Bench for up_sample_and_expand: three configurations checked against an
// arithmetic reference model plus directed expected sequences.
module tb_up_sample_and_expand;

  localparam int N = 3;
  int LOGS [N] = '{1, 2, 0};
  bit INTS [N] = '{1'b1, 1'b0, 1'b1};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid_in, ready_in, valid_out, ready_out;
  logic [7:0]     data_in  [N];
  logic [15:0]    data_out [N];

  always #5 clk = ~clk;

  up_sample_and_expand #(.UP_LOG2(1), .INTERP(1'b1)) u0 (
    .clk(clk), .rst(rst), .valid_in(valid_in[0]), .ready_in(ready_in[0]),
    .data_in(data_in[0]), .valid_out(valid_out[0]), .ready_out(ready_out[0]),
    .data_out(data_out[0]));
  up_sample_and_expand #(.UP_LOG2(2), .INTERP(1'b0)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in[1]), .ready_in(ready_in[1]),
    .data_in(data_in[1]), .valid_out(valid_out[1]), .ready_out(ready_out[1]),
    .data_out(data_out[1]));
  up_sample_and_expand #(.UP_LOG2(0), .INTERP(1'b1)) u2 (
    .clk(clk), .rst(rst), .valid_in(valid_in[2]), .ready_in(ready_in[2]),
    .data_in(data_in[2]), .valid_out(valid_out[2]), .ready_out(ready_out[2]),
    .data_out(data_out[2]));

  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          mprev [N];
  logic [15:0] exp_q [N][$];
  logic [15:0] got_q [N][$];
  int          got_t [N][$];
  bit          bp [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int expand(input logic [7:0] b);
    return (int'(b) - 128) * 256;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: beats k=1..L are prev + (x-prev)*k/L (or x when holding)
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int x;
      int l;
      if (rst) begin
        exp_q[i].delete();
        mprev[i] = 0;
      end else begin
        if (valid_out[i] && ready_out[i]) begin
          got_q[i].push_back(data_out[i]);
          got_t[i].push_back(cyc);
          if (exp_q[i].size() == 0) begin
            ncmp++;
            nfail++;
            $error("FAIL extra_beat%0d: observed %h, expected no beat", i, data_out[i]);
          end else begin
            check($sformatf("beat%0d", i), 32'(data_out[i]), 32'(exp_q[i].pop_front()));
          end
        end
        if (valid_in[i] && ready_in[i]) begin
          x = expand(data_in[i]);
          l = 1 << LOGS[i];
          for (int k = 1; k <= l; k++)
            exp_q[i].push_back(16'(INTS[i] ? mprev[i] + ((x - mprev[i]) * k) / l : x));
          mprev[i] = x;
        end
      end
    end
  end

  task automatic step(input int i);
    @(posedge clk);
    #1;
    if (bp[i]) ready_out[i] = 1'($urandom);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int n;
    n = 0;
    valid_in[i] = 1'b1;
    data_in[i]  = b;
    forever begin
      @(negedge clk);
      if (ready_in[i]) break;
      n++;
      if (n > 200) begin
        ncmp++;
        nfail++;
        $error("FAIL send_timeout%0d: observed no ready_in, expected accept", i);
        break;
      end
      step(i);
    end
    @(posedge clk);
    #1;
    valid_in[i] = 1'b0;
    if (bp[i]) ready_out[i] = 1'($urandom);
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) step(i);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    ready_out[i] = 1'b1;
    while ((exp_q[i].size() != 0 || valid_out[i]) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("drain_pending%0d", i), 32'(exp_q[i].size()), 32'd0);
    check($sformatf("drain_valid%0d", i), 32'(valid_out[i]), 32'd0);
  endtask

  task automatic expect_got(input int i, input string tag, input logic [15:0] e[$]);
    check({tag, "_count"}, 32'(got_q[i].size()), 32'(e.size()));
    for (int j = 0; j < e.size() && j < got_q[i].size(); j++)
      check($sformatf("%s_%0d", tag, j), 32'(got_q[i][j]), 32'(e[j]));
    got_q[i].delete();
    got_t[i].delete();
  endtask

  initial begin
    valid_in  = '0;
    ready_out = '1;
    for (int i = 0; i < N; i++) begin
      data_in[i] = 8'h00;
      mprev[i]   = 0;
      bp[i]      = 1'b0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_valid%0d", i), 32'(valid_out[i]), 32'd0);
      check($sformatf("rst_data%0d", i), 32'(data_out[i]), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      check($sformatf("rst_ready_in%0d", i), 32'(ready_in[i]), 32'd1);

    // 1: start-up interpolation from mid-scale, one-cycle latency
    send(0, 8'h80);
    check("t1_latency", 32'(valid_out[0]), 32'd1);
    send(0, 8'hC0);
    drain(0);
    expect_got(0, "t1", '{16'h0000, 16'h0000, 16'h2000, 16'h4000});

    // 2: negative full scale
    send(0, 8'h00);
    drain(0);
    expect_got(0, "t2", '{16'hE000, 16'h8000});

    // 3: backpressure holds everything and blocks input
    ready_out[0] = 1'b0;
    send(0, 8'h90);
    valid_in[0] = 1'b1;
    data_in[0]  = 8'hA0;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'(data_out[0]), 32'h0000C800);
      check("t3_hold_valid", 32'(valid_out[0]), 32'd1);
      check("t3_ready_in", 32'(ready_in[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_out[0] = 1'b1;
    send(0, 8'hA0);
    drain(0);
    expect_got(0, "t3", '{16'hC800, 16'h1000, 16'h1800, 16'h2000});

    // 4: gap-free streaming
    send(0, 8'h90);
    send(0, 8'hA0);
    send(0, 8'hB0);
    drain(0);
    if (got_t[0].size() == 6)
      check("t4_span", 32'(got_t[0][5] - got_t[0][0]), 32'd5);
    expect_got(0, "t4", '{16'h1800, 16'h1000, 16'h1800, 16'h2000, 16'h2800, 16'h3000});

    // 5: reset during the first beat
    send(0, 8'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_valid", 32'(valid_out[0]), 32'd0);
    check("t5_data", 32'(data_out[0]), 32'd0);
    check("t5_ready_in", 32'(ready_in[0]), 32'd1);
    got_q[0].delete();
    got_t[0].delete();
    send(0, 8'hFF);
    drain(0);
    expect_got(0, "t5", '{16'h3F80, 16'h7F00});

    // 6: zero-order hold x4, and pure format conversion
    send(1, 8'h40);
    drain(1);
    expect_got(1, "t6_zoh", '{16'hC000, 16'hC000, 16'hC000, 16'hC000});
    send(2, 8'h81);
    drain(2);
    expect_got(2, "t6_l1", '{16'h0100});

    // Random samples, gaps and backpressure against the model
    for (int i = 0; i < N; i++) begin
      bp[i] = 1'b1;
      repeat (i == 0 ? 24 : 10) begin
        if ($urandom_range(3) == 0) idle(i, $urandom_range(3, 1));
        send(i, 8'($urandom));
      end
      bp[i] = 1'b0;
      drain(i);
      got_q[i].delete();
      got_t[i].delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
